// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - 8N1 UART transmitter with small byte FIFO; UART_TX_PARITY_EN adds an even parity bit
module uart_tx_fifo #(
    parameter int CLK_PER_BIT = 176,
    parameter int FIFO_DEPTH  = 4,
    parameter int FIFO_AW     = 2
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [7:0]         tx_data,
    input  logic               tx_valid,
    output logic               tx_ready,
    output logic               uart_txd,
    output logic               tx_busy,
    output logic [FIFO_AW:0]   fifo_count
);

    localparam int CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [CW-1:0]    LAST_CYC = CW'(CLK_PER_BIT - 1);
    localparam logic [FIFO_AW:0] DEPTH    = (FIFO_AW + 1)'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    state_t             r_state, w_state_nxt;
    logic               r_txd, w_txd_nxt;
    logic [7:0]         r_shift, w_shift_nxt;
    logic [CW-1:0]      r_cyc, w_cyc_nxt;
    logic [2:0]         r_bit, w_bit_nxt;
    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [FIFO_AW:0]   r_count;
`ifdef UART_TX_PARITY_EN
    logic               r_parity, w_parity_nxt;
`endif

    logic       w_push, w_pop, w_empty, w_last_cyc;
    logic [7:0] w_head;

    assign tx_ready   = (r_count != DEPTH);
    assign w_push     = tx_valid && tx_ready;
    assign w_empty    = (r_count == '0);
    assign w_last_cyc = (r_cyc == LAST_CYC);
    assign w_head     = r_mem[r_rd_ptr];

    assign uart_txd   = r_txd;
    assign fifo_count = r_count;
    assign tx_busy    = (r_state != S_IDLE) || !w_empty;

    // Storage needs no reset: occupancy is tracked solely by the pointers and count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (FIFO_AW + 1)'(1);
                2'b01:   r_count <= r_count - (FIFO_AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_txd    <= 1'b1;
            r_shift  <= '0;
            r_cyc    <= '0;
            r_bit    <= '0;
`ifdef UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_txd    <= w_txd_nxt;
            r_shift  <= w_shift_nxt;
            r_cyc    <= w_cyc_nxt;
            r_bit    <= w_bit_nxt;
`ifdef UART_TX_PARITY_EN
            r_parity <= w_parity_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_txd_nxt    = r_txd;
        w_shift_nxt  = r_shift;
        w_cyc_nxt    = w_last_cyc ? '0 : r_cyc + CW'(1);
        w_bit_nxt    = r_bit;
        w_pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_parity_nxt = r_parity;
`endif
        case (r_state)
            S_IDLE: begin
                w_txd_nxt = 1'b1;
                w_cyc_nxt = '0;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_head;
                    w_txd_nxt   = 1'b0;
                    w_state_nxt = S_START;
`ifdef UART_TX_PARITY_EN
                    w_parity_nxt = ^w_head;
`endif
                end
            end
            S_START: begin
                if (w_last_cyc) begin
                    w_txd_nxt   = r_shift[0];
                    w_bit_nxt   = '0;
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_last_cyc) begin
                    if (r_bit == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        w_txd_nxt   = r_parity;
                        w_state_nxt = S_PARITY;
`else
                        w_txd_nxt   = 1'b1;
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                        w_txd_nxt   = r_shift[1];
                        w_bit_nxt   = r_bit + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_last_cyc) begin
                    w_txd_nxt   = 1'b1;
                    w_state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                // Popping here rather than via IDLE keeps queued frames gap-free.
                if (w_last_cyc) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_head;
                        w_txd_nxt   = 1'b0;
                        w_state_nxt = S_START;
`ifdef UART_TX_PARITY_EN
                        w_parity_nxt = ^w_head;
`endif
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_txd_nxt   = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo
module tb_uart_tx_fifo;

    localparam int CPB = 176;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME = 11 * CPB;
`else
    localparam int FRAME = 10 * CPB;
`endif
    localparam int STOP_K = FRAME / CPB - 1;
    localparam int HALF   = CPB / 2;

    logic       clk;
    logic       resetn;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       uart_txd;
    logic       tx_busy;
    logic [2:0] fifo_count;

    uart_tx_fifo #(.CLK_PER_BIT(CPB), .FIFO_DEPTH(4), .FIFO_AW(2)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .uart_txd   (uart_txd),
        .tx_busy    (tx_busy),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    logic [8:0] sb[$];
    int start_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic sb_push(input logic [7:0] b);
        sb.push_back({^b, b});
    endtask

    // Frame decoder: samples the line at the centre of every bit period.
    logic       mon_act = 1'b0;
    int         mon_pos = 0;
    logic [7:0] mon_byte;
    logic       mon_par = 1'b0;
    logic       mon_last_par = 1'b0;
    logic       mon_ok;
    logic [8:0] mon_exp;

    always @(negedge clk) begin
        if (!resetn) begin
            mon_act = 1'b0;
        end else if (!mon_act) begin
            if (uart_txd === 1'b0) begin
                mon_act = 1'b1;
                mon_pos = 0;
                start_q.push_back(cyc);
            end
        end else begin
            mon_pos++;
            if (mon_pos % CPB == HALF) begin
                if (mon_pos / CPB == 0) begin
                    mon_ok = (uart_txd === 1'b0);
                end else if (mon_pos / CPB <= 8) begin
                    mon_byte[mon_pos / CPB - 1] = uart_txd;
                end else if (mon_pos / CPB == STOP_K) begin
                    mon_ok = mon_ok && (uart_txd === 1'b1);
                    mon_act = 1'b0;
                    mon_last_par = mon_par;
                    if (sb.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL rx_unexpected: got 0x%0h expected no frame", mon_byte);
                    end else begin
                        mon_exp = sb.pop_front();
                        chk("rx_byte", {24'd0, mon_byte}, {24'd0, mon_exp[7:0]});
                        chk("rx_framing", {31'd0, mon_ok}, 32'd1);
`ifdef UART_TX_PARITY_EN
                        chk("rx_parity", {31'd0, mon_par}, {31'd0, mon_exp[8]});
`endif
                    end
                end else begin
                    mon_par = uart_txd;
                end
            end
        end
    end

    task automatic wait_idle(input string nm, output int t_end);
        int k;
        k = 0;
        @(negedge clk);
        while (tx_busy !== 1'b0 && k < 20000) begin
            @(negedge clk);
            k++;
        end
        if (tx_busy !== 1'b0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_timeout: busy=%0b expected 0", nm, tx_busy);
        end
        t_end = cyc;
    endtask

    logic [7:0] b2b  [4] = '{8'h30, 8'h00, 8'h10, 8'hFF};
    logic [7:0] fill [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    logic [7:0] sim  [4] = '{8'hC3, 8'h5A, 8'h81, 8'h7E};

    initial begin
        int t_end, n0, q, i, budget;
        logic full_seen, rise_done;

        resetn   = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst_txd",   {31'd0, uart_txd}, 32'd1);
        chk("rst_ready", {31'd0, tx_ready}, 32'd1);
        chk("rst_busy",  {31'd0, tx_busy},  32'd0);
        chk("rst_count", {29'd0, fifo_count}, 32'd0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // single byte: latency, bit pattern, busy fall time
        n0 = start_q.size();
        tx_valid = 1'b1; tx_data = 8'hA5; sb_push(8'hA5);
        @(negedge clk);
        tx_valid = 1'b0;
        chk("lat_txd_n1",   {31'd0, uart_txd}, 32'd1);
        chk("lat_count_n1", {29'd0, fifo_count}, 32'd1);
        chk("lat_busy_n1",  {31'd0, tx_busy}, 32'd1);
        @(negedge clk);
        chk("lat_txd_n2",   {31'd0, uart_txd}, 32'd0);
        chk("lat_count_n2", {29'd0, fifo_count}, 32'd0);
        wait_idle("single", t_end);
        chk("single_nframes", start_q.size(), n0 + 1);
        if (start_q.size() == n0 + 1)
            chk("single_busy_fall", t_end - start_q[n0], FRAME);

        // back-to-back frames
        n0 = start_q.size();
        for (int k = 0; k < 4; k++) begin
            tx_valid = 1'b1; tx_data = b2b[k]; sb_push(b2b[k]);
            @(negedge clk);
        end
        tx_valid = 1'b0;
        wait_idle("b2b", t_end);
        chk("b2b_nframes", start_q.size(), n0 + 4);
        if (start_q.size() == n0 + 4) begin
            for (int k = 1; k < 4; k++)
                chk("b2b_gap", start_q[n0 + k] - start_q[n0 + k - 1], FRAME);
            chk("b2b_total", t_end - start_q[n0], 4 * FRAME);
        end

        // fill past full with valid held high
        i = 0; budget = 0; full_seen = 1'b0; rise_done = 1'b0;
        while (i < 6 && budget < 5000) begin
            tx_valid = 1'b1;
            tx_data  = fill[i];
            if (fifo_count == 3'd4) begin
                if (!full_seen) chk("full_ready_low", {31'd0, tx_ready}, 32'd0);
                full_seen = 1'b1;
            end else if (full_seen && !rise_done) begin
                chk("pop_count", {29'd0, fifo_count}, 32'd3);
                chk("pop_ready_high", {31'd0, tx_ready}, 32'd1);
                rise_done = 1'b1;
            end
            if (tx_ready) begin
                sb_push(fill[i]);
                i++;
            end
            @(negedge clk);
            budget++;
        end
        tx_valid = 1'b0;
        chk("fill_all_accepted", i, 6);
        chk("fill_full_seen", {31'd0, full_seen}, 32'd1);
        chk("fill_rise_seen", {31'd0, rise_done}, 32'd1);
        wait_idle("fill", t_end);

        // simultaneous push and pop at a STOP->START boundary
        tx_valid = 1'b1; tx_data = sim[0]; sb_push(sim[0]);
        @(negedge clk);
        q = cyc;
        tx_data = sim[1]; sb_push(sim[1]);
        @(negedge clk);
        tx_data = sim[2]; sb_push(sim[2]);
        @(negedge clk);
        tx_valid = 1'b0;
        chk("sim_count_pre", {29'd0, fifo_count}, 32'd2);
        while (cyc < q + FRAME) @(negedge clk);
        chk("sim_count_edge", {29'd0, fifo_count}, 32'd2);
        tx_valid = 1'b1; tx_data = sim[3]; sb_push(sim[3]);
        @(negedge clk);
        tx_valid = 1'b0;
        chk("sim_count_post", {29'd0, fifo_count}, 32'd2);
        chk("sim_start_bit", {31'd0, uart_txd}, 32'd0);
        wait_idle("sim", t_end);

        // reset in the middle of a frame
        tx_valid = 1'b1; tx_data = 8'h00; sb_push(8'h00);
        @(negedge clk);
        sb_push(8'h00);
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (3 * CPB) @(negedge clk);
        chk("mid_txd_low", {31'd0, uart_txd}, 32'd0);
        n0 = start_q.size();
        #2 resetn = 1'b0;
        #1;
        chk("mid_rst_txd",   {31'd0, uart_txd}, 32'd1);
        chk("mid_rst_count", {29'd0, fifo_count}, 32'd0);
        chk("mid_rst_busy",  {31'd0, tx_busy}, 32'd0);
        repeat (3) @(negedge clk);
        sb.delete();
        #2 resetn = 1'b1;
        repeat (300) @(negedge clk);
        chk("mid_no_resume", start_q.size(), n0);
        chk("mid_idle_txd", {31'd0, uart_txd}, 32'd1);

`ifdef UART_TX_PARITY_EN
        n0 = start_q.size();
        tx_valid = 1'b1; tx_data = 8'h07; sb_push(8'h07);
        @(negedge clk);
        tx_valid = 1'b0;
        wait_idle("par07", t_end);
        chk("par07_bit", {31'd0, mon_last_par}, 32'd1);
        if (start_q.size() == n0 + 1)
            chk("par07_frame", t_end - start_q[n0], 1936);
        tx_valid = 1'b1; tx_data = 8'h03; sb_push(8'h03);
        @(negedge clk);
        tx_valid = 1'b0;
        wait_idle("par03", t_end);
        chk("par03_bit", {31'd0, mon_last_par}, 32'd0);
`endif

        repeat (10) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
